// File: rtl/tx_fifo_module_pkg.sv
// Shared definitions for the UART 8N1 transmit path.
// Holds the FSM state encoding, default timing and the frame length.
package tx_fifo_module_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DEF_BPS_CNT = 434;
  localparam int DEF_FIFO_AW = 2;
  localparam int FRAME_BITS  = 10;

endpackage

// File: rtl/tx_fifo_module_fifo.sv
// Small synchronous byte FIFO with first-word-fall-through read data.
// A push on a full FIFO is accepted only when a pop frees the slot in the same cycle.
module tx_fifo_module_fifo #(
  parameter int AW = 2,
  parameter int W  = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rd,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_pop  = i_rd & ~o_empty;
  assign w_push = i_wr & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/tx_fifo_module.sv
// UART 8N1 transmitter fed by a small byte FIFO; frames go out back-to-back
// while data is queued, and the line output is registered from the FSM state.
module tx_fifo_module
  import tx_fifo_module_pkg::*;
#(
  parameter int BPS_CNT = DEF_BPS_CNT,
  parameter int FIFO_AW = DEF_FIFO_AW
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [7:0]       TX_Data,
  input  logic             TX_Wr_Sig,
  output logic             TX_Full_Sig,
  output logic [FIFO_AW:0] TX_Level,
  output logic             TX_Busy_Sig,
  output logic             TX_Done_Sig,
  output logic             TX_Ovf_Sig,
  output logic             TX_Pin_Out
);

  localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BPS_CNT - 1);

  tx_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_bit_cnt, w_cnt_nxt;
  logic [2:0]    r_bit_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_pin, r_done, r_ovf;
  logic          w_line, w_done, w_pop, w_bit_end;
  logic          w_full, w_empty;
  logic [7:0]    w_rdata;

  tx_fifo_module_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_wr    (TX_Wr_Sig),
    .i_wdata (TX_Data),
    .i_rd    (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (TX_Level)
  );

  assign w_bit_end   = (r_bit_cnt == CNT_MAX);
  assign TX_Full_Sig = w_full;
  assign TX_Busy_Sig = (r_state != ST_IDLE);
  assign TX_Done_Sig = r_done;
  assign TX_Ovf_Sig  = r_ovf;
  assign TX_Pin_Out  = r_pin;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_line      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rdata;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_line = 1'b0;
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        w_line = r_shift[0];
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
          else                   w_idx_nxt   = r_bit_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        // A queued byte starts its start bit right after this stop bit.
        if (w_bit_end) begin
          w_done    = 1'b1;
          w_cnt_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_rdata;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_pin     <= 1'b1;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_pin     <= w_line;
      r_done    <= w_done;
      r_ovf     <= r_ovf | (TX_Wr_Sig & w_full & ~w_pop);
    end
  end

endmodule

// File: tb/tb_tx_fifo_module.sv
// Directed bench for tx_fifo_module with BPS_CNT=4 and a 4-deep FIFO.
// Expected line values come from a bit-level frame model of each byte.
module tb_tx_fifo_module;
  import tx_fifo_module_pkg::*;

  localparam int BPS   = 4;
  localparam int AW    = 2;
  localparam int FRAME = FRAME_BITS * BPS;

  logic        clock = 1'b0;
  logic        rstN;
  logic [7:0]  txData;
  logic        txWr;
  logic        txFull;
  logic [AW:0] txLevel;
  logic        txBusy;
  logic        txDone;
  logic        txOvf;
  logic        txPin;

  int vectorCount = 0;
  int missCount   = 0;

  tx_fifo_module #(.BPS_CNT(BPS), .FIFO_AW(AW)) dut (
    .CLK         (clock),
    .RSTn        (rstN),
    .TX_Data     (txData),
    .TX_Wr_Sig   (txWr),
    .TX_Full_Sig (txFull),
    .TX_Level    (txLevel),
    .TX_Busy_Sig (txBusy),
    .TX_Done_Sig (txDone),
    .TX_Ovf_Sig  (txOvf),
    .TX_Pin_Out  (txPin)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one write strobe (or idles the strobe) for the next edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] data);
    txWr   = wr;
    txData = data;
  endtask

  function automatic logic expectedPin(input logic [7:0] b, input int j);
    if (j == 0)      return 1'b0;
    else if (j <= 8) return b[j-1];
    else             return 1'b1;
  endfunction

  // Entered at #1 after line-cycle firstK-1 of the frame (cycle 0 is the pop edge).
  task automatic checkFrame(input logic [7:0] b, input int firstK, input int lastK);
    for (int k = firstK; k <= lastK; k++) begin
      tick();
      checkOutput($sformatf("pin byte %02h cyc %0d", b, k), 32'(txPin), 32'(expectedPin(b, (k - 1) / BPS)));
      checkOutput($sformatf("done byte %02h cyc %0d", b, k), 32'(txDone), 32'(k == FRAME));
      if (k < FRAME) checkOutput($sformatf("busy byte %02h cyc %0d", b, k), 32'(txBusy), 32'd1);
    end
  endtask

  task automatic checkIdle(input string tag, input int ovf);
    checkOutput({tag, " busy"},  32'(txBusy),  32'd0);
    checkOutput({tag, " level"}, 32'(txLevel), 32'd0);
    checkOutput({tag, " full"},  32'(txFull),  32'd0);
    checkOutput({tag, " ovf"},   32'(txOvf),   32'(ovf));
    checkOutput({tag, " pin"},   32'(txPin),   32'd1);
  endtask

  initial begin
    int lvl4[6];
    int full4[6];
    int ovf4[6];
    int lvl5[5];
    lvl4  = '{1, 1, 2, 3, 4, 4};
    full4 = '{0, 0, 0, 0, 1, 1};
    ovf4  = '{0, 0, 0, 0, 0, 1};
    lvl5  = '{1, 1, 2, 3, 4};

    rstN = 1'b0;
    applyStimulus(1'b0, 8'h00);
    repeat (3) tick();
    checkIdle("reset", 0);
    checkOutput("reset done", 32'(txDone), 32'd0);
    rstN = 1'b1;
    tick();
    checkIdle("post-reset", 0);

    $display("[TB] single byte 0xA5");
    applyStimulus(1'b1, 8'hA5);
    tick();
    checkOutput("a5 level after write", 32'(txLevel), 32'd1);
    checkOutput("a5 busy after write",  32'(txBusy),  32'd0);
    checkOutput("a5 pin after write",   32'(txPin),   32'd1);
    applyStimulus(1'b0, 8'h00);
    tick();
    checkOutput("a5 busy after pop",  32'(txBusy),  32'd1);
    checkOutput("a5 level after pop", 32'(txLevel), 32'd0);
    checkOutput("a5 pin at pop",      32'(txPin),   32'd1);
    checkFrame(8'hA5, 1, FRAME);
    checkIdle("a5 end", 0);
    tick();
    checkOutput("a5 done single pulse", 32'(txDone), 32'd0);
    checkOutput("a5 pin idle",          32'(txPin),  32'd1);

    $display("[TB] burst 01 02 03");
    applyStimulus(1'b1, 8'h01);
    tick();
    checkOutput("burst level 1", 32'(txLevel), 32'd1);
    applyStimulus(1'b1, 8'h02);
    tick();
    checkOutput("burst level 2", 32'(txLevel), 32'd1);
    applyStimulus(1'b1, 8'h03);
    tick();
    checkOutput("burst level 3", 32'(txLevel), 32'd2);
    checkOutput("burst start pin", 32'(txPin), 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkFrame(8'h01, 2, FRAME);
    checkOutput("burst busy b2b", 32'(txBusy), 32'd1);
    checkOutput("burst level after 2nd pop", 32'(txLevel), 32'd1);
    checkFrame(8'h02, 1, FRAME);
    checkOutput("burst level after 3rd pop", 32'(txLevel), 32'd0);
    checkFrame(8'h03, 1, FRAME);
    checkIdle("burst end", 0);

    $display("[TB] push while full on pop cycle");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h21 + 8'(i));
      tick();
      checkOutput($sformatf("pf level w%0d", i), 32'(txLevel), 32'(lvl5[i]));
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("pf full", 32'(txFull), 32'd1);
    checkFrame(8'h21, 4, FRAME - 1);
    applyStimulus(1'b1, 8'h26);
    checkFrame(8'h21, FRAME, FRAME);
    applyStimulus(1'b0, 8'h00);
    checkOutput("pf level held", 32'(txLevel), 32'd4);
    checkOutput("pf full held",  32'(txFull),  32'd1);
    checkOutput("pf no ovf",     32'(txOvf),   32'd0);
    for (int i = 0; i < 5; i++) checkFrame(8'h22 + 8'(i), 1, FRAME);
    checkIdle("pf end", 0);

    $display("[TB] overflow");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'h11 + 8'(i));
      tick();
      checkOutput($sformatf("ovf level w%0d", i), 32'(txLevel), 32'(lvl4[i]));
      checkOutput($sformatf("ovf full w%0d", i),  32'(txFull),  32'(full4[i]));
      checkOutput($sformatf("ovf flag w%0d", i),  32'(txOvf),   32'(ovf4[i]));
    end
    applyStimulus(1'b0, 8'h00);
    checkFrame(8'h11, 5, FRAME);
    checkOutput("ovf level after pop", 32'(txLevel), 32'd3);
    for (int i = 1; i < 5; i++) checkFrame(8'h11 + 8'(i), 1, FRAME);
    checkIdle("ovf end", 1);
    tick();
    checkOutput("ovf dropped byte not sent", 32'(txBusy), 32'd0);
    checkOutput("ovf sticky", 32'(txOvf), 32'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h5A);
    tick();
    applyStimulus(1'b1, 8'h5B);
    tick();
    applyStimulus(1'b1, 8'h5C);
    tick();
    checkOutput("mid level", 32'(txLevel), 32'd2);
    applyStimulus(1'b0, 8'h00);
    checkFrame(8'h5A, 2, 17);
    rstN = 1'b0;
    tick();
    checkIdle("mid reset", 0);
    checkOutput("mid reset done", 32'(txDone), 32'd0);
    rstN = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      checkOutput($sformatf("post-abort pin %0d", i),  32'(txPin),  32'd1);
      checkOutput($sformatf("post-abort done %0d", i), 32'(txDone), 32'd0);
      checkOutput($sformatf("post-abort busy %0d", i), 32'(txBusy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
